// File: rtl/i2c_ssd1306_target.sv
// Write-only I2C target modelling the SSD1306 receive path: START/STOP detect, address match,
// control-byte decode (Co, D/C#) and a one-cycle strobe per received payload byte.
module i2c_ssd1306_target #(
    parameter int                    ADDR_WIDTH  = 7,
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] TARGET_ADDR = 7'h3C,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_scl,
    inout  wire                   io_sda,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_dc,
    output logic                  o_frame_end,
    output logic                  o_addr_nack,
    output logic                  o_busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        IGNORE,
        ACK_A,
        ACK_C,
        ACK_D,
        CTRL,
        DATA
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl, sda, scl_d, sda_d;
    logic                   scl_rise, scl_fall, start_det, stop_det;
    logic                   bit_en, byte_done, addr_ok;
    logic [DATA_WIDTH-1:0]  shreg, rx_byte;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   co, dc;
    logic                   sda_drive, drive_next;

    // Synchronisers reset to the idle-bus level so reset release never looks like a START.
    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], i_scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], io_sda};
            scl_d    <= scl;
            sda_d    <= sda;
        end
    end

    assign scl       = scl_sync[SYNC_STAGES-1];
    assign sda       = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl & ~scl_d;
    assign scl_fall  = ~scl & scl_d;
    assign start_det = scl & sda_d & ~sda;
    assign stop_det  = scl & ~sda_d & sda;

    // A coincident START/STOP suppresses the SCL edge in the same cycle.
    assign bit_en    = (state == ADDR || state == CTRL || state == DATA)
                       && scl_rise && !start_det && !stop_det;
    assign byte_done = bit_en && (bit_cnt == CNT_W'(DATA_WIDTH-1));
    assign rx_byte   = {shreg[DATA_WIDTH-2:0], sda};
    assign addr_ok   = (rx_byte[DATA_WIDTH-1 -: ADDR_WIDTH] == TARGET_ADDR) && !rx_byte[0];

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            state     <= IDLE;
            sda_drive <= 1'b0;
        end else begin
            state     <= state_next;
            sda_drive <= drive_next;
        end
    end

    always_comb begin
        state_next = state;
        drive_next = sda_drive;
        if (start_det) begin
            state_next = ADDR;
            drive_next = 1'b0;
        end else if (stop_det) begin
            state_next = IDLE;
            drive_next = 1'b0;
        end else begin
            case (state)
                ADDR:    if (byte_done) state_next = addr_ok ? ACK_A : IGNORE;
                CTRL:    if (byte_done) state_next = ACK_C;
                DATA:    if (byte_done) state_next = ACK_D;
                ACK_A, ACK_C, ACK_D: begin
                    // First fall after bit 8 pulls SDA low; the following fall ends the ACK slot.
                    if (scl_fall) begin
                        if (!sda_drive) begin
                            drive_next = 1'b1;
                        end else begin
                            drive_next = 1'b0;
                            case (state)
                                ACK_A:   state_next = CTRL;
                                ACK_C:   state_next = DATA;
                                default: state_next = co ? CTRL : DATA;
                            endcase
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            shreg       <= '0;
            bit_cnt     <= '0;
            co          <= 1'b0;
            dc          <= 1'b0;
            o_valid     <= 1'b0;
            o_data      <= '0;
            o_dc        <= 1'b0;
            o_frame_end <= 1'b0;
            o_addr_nack <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_valid     <= 1'b0;
            o_frame_end <= 1'b0;
            o_addr_nack <= 1'b0;
            if (start_det) begin
                bit_cnt <= '0;
                o_busy  <= 1'b0;
            end else if (stop_det) begin
                bit_cnt     <= '0;
                o_frame_end <= o_busy;
                o_busy      <= 1'b0;
            end else begin
                if (bit_en) begin
                    shreg   <= rx_byte;
                    bit_cnt <= bit_cnt + 1'b1;
                end
                if (byte_done) begin
                    case (state)
                        ADDR: begin
                            if (addr_ok) o_busy      <= 1'b1;
                            else         o_addr_nack <= 1'b1;
                        end
                        CTRL: begin
                            co <= rx_byte[DATA_WIDTH-1];
                            dc <= rx_byte[DATA_WIDTH-2];
                        end
                        DATA: begin
                            o_valid <= 1'b1;
                            o_data  <= rx_byte;
                            o_dc    <= dc;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign io_sda = sda_drive ? 1'b0 : 1'bz;

endmodule
